rr_arb_ctrl: RTL and testbench

- Sequential control stage of the router's round-robin output arbiter.
- Drives the rotating-priority pointer into the combinational priority selector and consumes that selector's one-hot result.
- Registers and locks the grant for the whole packet, then advances the pointer past the winner for fairness.
- One instance per router output port.

---
 rtl/rr_arb_ctrl.sv | 114 +++++++++++
 tb/tb_rr_arb_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl: sequential control stage of a round-robin output arbiter.
// Drives the rotating priority pointer into an external combinational
// priority selector. Captures the selector's one-hot winner and holds it
// locked for the whole packet. On release, moves the pointer past the winner.
module rr_arb_ctrl #(
  parameter int unsigned SIZE = 10,
  parameter int unsigned PW   = $clog2(SIZE)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [SIZE-1:0] in_req,
  input  logic            in_release,
  input  logic [SIZE-1:0] sel_in,
  output logic [PW-1:0]   prio,
  output logic [SIZE-1:0] grant,
  output logic            grant_valid,
  output logic [PW-1:0]   grant_id,
  output logic            err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [SIZE-1:0] grant_n;
  logic [PW-1:0]   grant_id_n;
  logic [PW-1:0]   prio_n;
  logic            err_n;

  logic [SIZE-1:0] low_onehot;
  logic [PW-1:0]   low_idx;
  logic            low_found;
  logic            multi_hot;
  logic            release_now;
  logic [PW-1:0]   prio_after;

  // Isolate the lowest set bit of sel_in, its binary index, and flag multi-hot selections
  always_comb begin
    low_onehot = sel_in & (~sel_in + SIZE'(1));
    multi_hot  = (sel_in & (sel_in - SIZE'(1))) != '0;
    low_idx    = '0;
    low_found  = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!low_found && sel_in[i]) begin
        low_idx   = PW'(i);
        low_found = 1'b1;
      end
    end
  end

  // Release on packet tail or when the granted requester abandons its request.
  // The pointer advances modulo SIZE using a compare-and-wrap.
  always_comb begin
    release_now = in_release || ((in_req & grant) == '0);
    prio_after  = (grant_id == PW'(SIZE - 1)) ? '0 : grant_id + PW'(1);
  end

  // Next-state logic and output updates for the IDLE/BUSY lock FSM
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    prio_n     = prio;
    err_n      = err;
    case (state)
      IDLE: begin
        if (enable && (sel_in != '0)) begin
          grant_n    = low_onehot;
          grant_id_n = low_idx;
          state_n    = BUSY;
          if (multi_hot) begin
            err_n = 1'b1;
          end
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_n    = '0;
          grant_id_n = '0;
          prio_n     = prio_after;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = '0;
      end
    endcase
  end

  // State and output registers; reset drops any held grant immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      prio     <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      prio     <= prio_n;
      err      <= err_n;
    end
  end

  assign grant_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Scoreboard bench for rr_arb_ctrl. It contains a rotating-priority selector
// model that produces sel_in, and this model can be overridden.
module tb_rr_arb_ctrl;
  localparam int unsigned SIZE = 10;
  localparam int unsigned PW   = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [SIZE-1:0] in_req;
  logic            in_release;
  logic [SIZE-1:0] sel_in;
  logic [SIZE-1:0] sel_model;
  logic [SIZE-1:0] force_val;
  logic            force_en;
  logic [PW-1:0]   prio;
  logic [SIZE-1:0] grant;
  logic            grant_valid;
  logic [PW-1:0]   grant_id;
  logic            err;

  typedef struct {
    logic [SIZE-1:0] g;
    logic [PW-1:0]   id;
    logic [PW-1:0]   p;
    logic            v;
    logic            e;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  int ids [4] = '{3, 4, 5, 0};
  int prv [4] = '{3, 4, 5, 6};
  int pnx [4] = '{4, 5, 6, 1};

  always #5 clock = ~clock;

  rr_arb_ctrl #(.SIZE(SIZE), .PW(PW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_req      (in_req),
    .in_release  (in_release),
    .sel_in      (sel_in),
    .prio        (prio),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .err         (err)
  );

  // Rotating-priority selector: first requester at or after prio, wrapping
  always_comb begin
    sel_model = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (sel_model == '0 && in_req[(int'(prio) + k) % SIZE]) begin
        sel_model[(int'(prio) + k) % SIZE] = 1'b1;
      end
    end
  end

  assign sel_in = force_en ? force_val : sel_model;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [SIZE-1:0] g, input int id, input int p,
                          input logic v, input logic e);
    exp_t x;
    x.g = g; x.id = PW'(id); x.p = PW'(p); x.v = v; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic compare_front(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check_eq({tag, "_grant"}, 32'(grant),       32'(x.g));
      check_eq({tag, "_id"},    32'(grant_id),    32'(x.id));
      check_eq({tag, "_prio"},  32'(prio),        32'(x.p));
      check_eq({tag, "_valid"}, 32'(grant_valid), 32'(x.v));
      check_eq({tag, "_err"},   32'(err),         32'(x.e));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    #1;
    compare_front(tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; in_req = '0; in_release = 1'b0;
    force_en = 1'b0; force_val = '0;
    repeat (2) @(posedge clock);
    #1;
    push_exp('0, 0, 0, 1'b0, 1'b0);
    compare_front("rst");
    reset = 1'b0;

    // First grant goes to the lowest requester, then the pointer advances and an IDLE bubble follows
    in_req = 10'b0000111101; enable = 1'b1;
    push_exp(10'h001, 0, 0, 1'b1, 1'b0); tick("t2_grant");
    in_release = 1'b1;
    push_exp('0, 0, 1, 1'b0, 1'b0);      tick("t2_rel");
    in_release = 1'b0;
    push_exp(10'h004, 2, 1, 1'b1, 1'b0); tick("t2_next");
    push_exp(10'h004, 2, 1, 1'b1, 1'b0); tick("t2_hold");
    in_release = 1'b1;
    push_exp('0, 0, 3, 1'b0, 1'b0);      tick("t3_rel2");

    // Fairness round: requesters are served in order 3, 4, 5 and then wrap to 0
    for (int i = 0; i < 4; i++) begin
      in_release = 1'b0;
      push_exp(SIZE'(1) << ids[i], ids[i], prv[i], 1'b1, 1'b0); tick("t3_grant");
      in_release = 1'b1;
      push_exp('0, 0, pnx[i], 1'b0, 1'b0);                      tick("t3_rel");
    end

    // Pointer wrap from the top index
    in_release = 1'b0; in_req = 10'b1000000000;
    push_exp(10'h200, 9, 1, 1'b1, 1'b0); tick("t4_grant");
    in_release = 1'b1;
    push_exp('0, 0, 0, 1'b0, 1'b0);      tick("t4_wrap");

    // Abandonment releases without in_release; enable low blocks any grant
    in_release = 1'b0; in_req = 10'h008;
    push_exp(10'h008, 3, 0, 1'b1, 1'b0); tick("t5_grant");
    in_req = '0;
    push_exp('0, 0, 4, 1'b0, 1'b0);      tick("t5_abandon");
    enable = 1'b0; in_req = 10'b0000111101;
    for (int i = 0; i < 3; i++) begin
      in_release = (i == 1);
      push_exp('0, 0, 4, 1'b0, 1'b0);    tick("t5_noen");
    end

    // Multi-hot selection grants the lowest index and sets a sticky err
    in_release = 1'b0; enable = 1'b1; force_en = 1'b1; force_val = 10'b0000100100;
    push_exp(10'h004, 2, 4, 1'b1, 1'b1); tick("t6_multi");
    force_en = 1'b0;
    push_exp(10'h004, 2, 4, 1'b1, 1'b1); tick("t6_hold");
    in_release = 1'b1;
    push_exp('0, 0, 3, 1'b0, 1'b1);      tick("t6_rel");
    in_release = 1'b0;
    push_exp(10'h008, 3, 3, 1'b1, 1'b1); tick("t6_sticky");
    in_release = 1'b1;
    push_exp('0, 0, 4, 1'b0, 1'b1);      tick("t6_rel2");

    // Asynchronous reset in the middle of a cycle while BUSY
    in_release = 1'b0; in_req = 10'h004;
    push_exp(10'h004, 2, 4, 1'b1, 1'b1); tick("t1_busy");
    #3 reset = 1'b1;
    #1;
    push_exp('0, 0, 0, 1'b0, 1'b0);
    compare_front("t1_async");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
